// File: rtl/bcast_load_checker.sv
// Load-end monitor for a broadcast net: aligns each load branch against a
// DEPTH-cycle delayed copy of the driver value and records any disagreement.
module bcast_load_checker #(
  parameter int NUM_LOADS = 2,
  parameter int DEPTH     = 1,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clr,
  input  logic                 drv_in,
  input  logic [NUM_LOADS-1:0] load_in,
  output logic                 checking_o,
  output logic                 mismatch_o,
  output logic [NUM_LOADS-1:0] mismatch_vec_o,
  output logic                 err_sticky_o,
  output logic [CNT_W-1:0]     err_count_o,
  output logic [3:0]           first_fail_o
);

  typedef enum logic [1:0] {IDLE, FILL, CHECK} state_t;

  state_t               state_q, state_d;
  logic [2:0]           fill_q, fill_d;
  logic [DEPTH-1:0]     dly_q, dly_d;
  logic                 ref_bit;
  logic [NUM_LOADS-1:0] raw;
  logic [NUM_LOADS-1:0] vec_q;
  logic                 mis_q;
  logic                 sticky_q, sticky_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           ff_q, ff_d;
  logic [3:0]           low_idx;
  logic                 found;

  assign ref_bit = dly_q[DEPTH-1];

  // Written as a loop so DEPTH=1 needs no zero-width slice.
  always_comb begin
    dly_d    = dly_q;
    dly_d[0] = drv_in;
    for (int unsigned i = 1; i < DEPTH; i++) dly_d[i] = dly_q[i-1];
  end

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = FILL;
          fill_d  = 3'(DEPTH - 1);
        end
      end
      FILL: begin
        if (!en)              state_d = IDLE;
        else if (fill_q == '0) state_d = CHECK;
        else                  fill_d  = fill_q - 3'd1;
      end
      CHECK: begin
        if (!en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    raw     = '0;
    low_idx = '0;
    found   = 1'b0;
    if (state_q == CHECK) raw = load_in ^ {NUM_LOADS{ref_bit}};
    for (int unsigned i = 0; i < NUM_LOADS; i++) begin
      if (raw[i] && !found) begin
        low_idx = 4'(i);
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    ff_d     = ff_q;
    if (clr) begin
      cnt_d    = '0;
      sticky_d = 1'b0;
      ff_d     = '0;
    end else if (|raw) begin
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      if (!sticky_q) begin
        sticky_d = 1'b1;
        ff_d     = low_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      fill_q   <= '0;
      dly_q    <= '0;
      vec_q    <= '0;
      mis_q    <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      ff_q     <= '0;
    end else begin
      state_q  <= state_d;
      fill_q   <= fill_d;
      dly_q    <= dly_d;
      vec_q    <= raw;
      mis_q    <= |raw;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      ff_q     <= ff_d;
    end
  end

  assign checking_o     = (state_q == CHECK);
  assign mismatch_o     = mis_q;
  assign mismatch_vec_o = vec_q;
  assign err_sticky_o   = sticky_q;
  assign err_count_o    = cnt_q;
  assign first_fail_o   = ff_q;

endmodule

// File: tb/tb_bcast_load_checker.sv
// Bench for bcast_load_checker: two instances (2 loads/DEPTH 1/8-bit count and
// 4 loads/DEPTH 4/2-bit count) checked against a run-length/history model.
module tb_bcast_load_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2];
  logic        en  [2];
  logic        clr [2];
  logic        drv [2];
  logic [15:0] ld  [2];

  logic       chk_a, mis_a, stk_a;
  logic [1:0] vec_a;
  logic [7:0] cnt_a;
  logic [3:0] ff_a;
  logic       chk_b, mis_b, stk_b;
  logic [3:0] vec_b;
  logic [1:0] cnt_b;
  logic [3:0] ff_b;

  bcast_load_checker #(.NUM_LOADS(2), .DEPTH(1), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst[0]), .en(en[0]), .clr(clr[0]), .drv_in(drv[0]),
    .load_in(ld[0][1:0]), .checking_o(chk_a), .mismatch_o(mis_a),
    .mismatch_vec_o(vec_a), .err_sticky_o(stk_a), .err_count_o(cnt_a),
    .first_fail_o(ff_a));

  bcast_load_checker #(.NUM_LOADS(4), .DEPTH(4), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst[1]), .en(en[1]), .clr(clr[1]), .drv_in(drv[1]),
    .load_in(ld[1][3:0]), .checking_o(chk_b), .mismatch_o(mis_b),
    .mismatch_vec_o(vec_b), .err_sticky_o(stk_b), .err_count_o(cnt_b),
    .first_fail_o(ff_b));

  int checks = 0;
  int errs   = 0;

  function automatic int dep(int i);  return (i == 0) ? 1 : 4;   endfunction
  function automatic int nl(int i);   return (i == 0) ? 2 : 4;   endfunction
  function automatic int cmax(int i); return (i == 0) ? 255 : 3; endfunction
  function automatic logic [15:0] lmask(int i);
    return (16'h1 << nl(i)) - 16'h1;
  endfunction

  // Reference model: driver history per cycle, and a count of consecutive
  // enabled cycles; CHECK holds once DEPTH+1 such cycles have elapsed.
  int          cyc = 0;
  int          run      [2];
  int          last_rst [2];
  bit          dh       [2][4096];
  bit          e_chk    [2];
  bit          e_mis    [2];
  logic [15:0] e_vec    [2];
  bit          e_stk    [2];
  int          e_cnt    [2];
  int          e_ff     [2];

  function automatic bit ref_of(int i, int t);
    int k;
    k = t - dep(i);
    if (k < 0 || k <= last_rst[i]) return 1'b0;
    return dh[i][k % 4096];
  endfunction

  initial begin
    for (int i = 0; i < 2; i++) begin
      run[i] = 0; last_rst[i] = -1; e_chk[i] = 0; e_mis[i] = 0;
      e_vec[i] = '0; e_stk[i] = 0; e_cnt[i] = 0; e_ff[i] = 0;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [15:0] raw;
      raw = '0;
      if (rst[i]) begin
        e_chk[i] = 0; e_mis[i] = 0; e_vec[i] = '0; e_stk[i] = 0;
        e_cnt[i] = 0; e_ff[i] = 0; run[i] = 0; last_rst[i] = cyc;
      end else begin
        if (e_chk[i])
          raw = (ld[i] ^ (ref_of(i, cyc) ? 16'hFFFF : 16'h0)) & lmask(i);
        e_vec[i] = raw;
        e_mis[i] = (raw != 0);
        if (clr[i]) begin
          e_cnt[i] = 0; e_stk[i] = 0; e_ff[i] = 0;
        end else if (raw != 0) begin
          if (e_cnt[i] < cmax(i)) e_cnt[i]++;
          if (!e_stk[i]) begin
            e_stk[i] = 1;
            for (int j = nl(i) - 1; j >= 0; j--) if (raw[j]) e_ff[i] = j;
          end
        end
        run[i]   = en[i] ? run[i] + 1 : 0;
        e_chk[i] = (run[i] >= dep(i) + 1);
      end
      dh[i][cyc % 4096] = drv[i];
    end
    cyc++;
  end

  function automatic logic [31:0] exp_word(int i);
    if (i == 0)
      return {15'b0, e_chk[0], e_mis[0], e_vec[0][1:0], e_stk[0], 8'(e_cnt[0]), 4'(e_ff[0])};
    return {19'b0, e_chk[1], e_mis[1], e_vec[1][3:0], e_stk[1], 2'(e_cnt[1]), 4'(e_ff[1])};
  endfunction

  function automatic logic [31:0] obs_word(int i);
    if (i == 0) return {15'b0, chk_a, mis_a, vec_a, stk_a, cnt_a, ff_a};
    return {19'b0, chk_b, mis_b, vec_b, stk_b, cnt_b, ff_b};
  endfunction

  // Loads follow the aligned driver value, optionally with branches inverted.
  task automatic drive(int i, bit r, bit e, bit c, logic [15:0] flips);
    rst[i] = r;
    en[i]  = e;
    clr[i] = c;
    drv[i] = 1'($urandom);
    ld[i]  = ((ref_of(i, cyc) ? 16'hFFFF : 16'h0) ^ flips) & lmask(i);
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) drive(i, 1'b1, 1'b0, 1'b0, 16'h0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs_word(i) !== 32'h0) begin
        errs++;
        $display("FAIL reset inst=%0d got=%h exp=%h", i, obs_word(i), 32'h0);
      end
      drive(i, 1'b0, 1'b0, 1'b0, 16'h0);
    end
  endtask

  task automatic test_clean_run;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      checks++;
      if (obs_word(0) !== exp_word(0)) begin
        errs++;
        $display("FAIL clean_run cyc=%0d got=%h exp=%h", cyc, obs_word(0), exp_word(0));
      end
      drive(0, 1'b0, 1'b1, 1'b0, 16'h0);
    end
    @(negedge clk);
    checks++;
    if ({chk_a, mis_a, cnt_a} !== {1'b1, 1'b0, 8'd0}) begin
      errs++;
      $display("FAIL clean_run_end got=%h exp=%h", {chk_a, mis_a, cnt_a}, {1'b1, 1'b0, 8'd0});
    end
  endtask

  task automatic test_single_branch;
    logic [15:0] pat [8] = '{16'h0, 16'h2, 16'h2, 16'h2, 16'h0, 16'h0, 16'h0, 16'h0};
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      checks++;
      if (obs_word(0) !== exp_word(0)) begin
        errs++;
        $display("FAIL single_branch cyc=%0d got=%h exp=%h", cyc, obs_word(0), exp_word(0));
      end
      drive(0, 1'b0, 1'b1, (c == 0), pat[c]);
    end
    @(negedge clk);
    checks++;
    if ({stk_a, cnt_a, ff_a} !== {1'b1, 8'd3, 4'd1}) begin
      errs++;
      $display("FAIL single_branch_end got=%h exp=%h", {stk_a, cnt_a, ff_a}, {1'b1, 8'd3, 4'd1});
    end
  endtask

  task automatic test_first_fail_order;
    logic [15:0] pat [7] = '{16'h0, 16'h3, 16'h0, 16'h0, 16'h2, 16'h0, 16'h0};
    for (int c = 0; c < 7; c++) begin
      if (c > 0) @(negedge clk);
      checks++;
      if (obs_word(0) !== exp_word(0)) begin
        errs++;
        $display("FAIL first_fail cyc=%0d got=%h exp=%h", cyc, obs_word(0), exp_word(0));
      end
      drive(0, 1'b0, 1'b1, (c == 0), pat[c]);
    end
    @(negedge clk);
    checks++;
    if ({stk_a, cnt_a, ff_a} !== {1'b1, 8'd2, 4'd0}) begin
      errs++;
      $display("FAIL first_fail_end got=%h exp=%h", {stk_a, cnt_a, ff_a}, {1'b1, 8'd2, 4'd0});
    end
  endtask

  task automatic test_rst_mid_check;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (obs_word(0) !== exp_word(0)) begin
        errs++;
        $display("FAIL rst_mid cyc=%0d got=%h exp=%h", cyc, obs_word(0), exp_word(0));
      end
      drive(0, (c == 5), 1'b1, 1'b0, (c >= 3) ? 16'h1 : 16'h0);
    end
    @(negedge clk);
    checks++;
    if (obs_word(0) !== 32'h0) begin
      errs++;
      $display("FAIL rst_mid_zero got=%h exp=%h", obs_word(0), 32'h0);
    end
    drive(0, 1'b0, 1'b1, 1'b0, 16'h0);
    @(negedge clk);
    checks++;
    if (chk_a !== 1'b0) begin
      errs++;
      $display("FAIL rst_mid_refill got=%b exp=%b", chk_a, 1'b0);
    end
    for (int c = 0; c < 4; c++) begin
      drive(0, 1'b0, 1'b1, 1'b0, 16'h0);
      @(negedge clk);
      checks++;
      if (obs_word(0) !== exp_word(0)) begin
        errs++;
        $display("FAIL rst_mid_after cyc=%0d got=%h exp=%h", cyc, obs_word(0), exp_word(0));
      end
    end
  endtask

  task automatic test_fill_abort;
    int rise;
    drive(1, 1'b0, 1'b0, 1'b0, 16'h0);
    repeat (2) @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      drive(1, 1'b0, (c < 2), 1'b0, 16'hF);
      @(negedge clk);
      checks++;
      if (obs_word(1) !== exp_word(1) || chk_b !== 1'b0 || mis_b !== 1'b0) begin
        errs++;
        $display("FAIL fill_abort cyc=%0d got=%h exp=%h", cyc, obs_word(1), exp_word(1));
      end
    end
    rise = -1;
    for (int k = 1; k <= 20 && rise < 0; k++) begin
      drive(1, 1'b0, 1'b1, 1'b0, 16'h0);
      @(negedge clk);
      if (chk_b === 1'b1) rise = k;
    end
    checks++;
    if (rise != dep(1) + 1) begin
      errs++;
      $display("FAIL fill_latency got=%0d exp=%0d", rise, dep(1) + 1);
    end
  endtask

  task automatic test_saturation;
    for (int c = 0; c < 9; c++) begin
      drive(1, 1'b0, 1'b1, 1'b0, (c < 6) ? 16'(1 + $urandom_range(0, 14)) : 16'h0);
      @(negedge clk);
      checks++;
      if (obs_word(1) !== exp_word(1)) begin
        errs++;
        $display("FAIL saturation cyc=%0d got=%h exp=%h", cyc, obs_word(1), exp_word(1));
      end
    end
    checks++;
    if (cnt_b !== 2'd3) begin
      errs++;
      $display("FAIL saturation_hold got=%0d exp=%0d", cnt_b, 3);
    end
    drive(1, 1'b0, 1'b1, 1'b1, 16'h5);
    @(negedge clk);
    checks++;
    if ({stk_b, cnt_b, ff_b} !== {1'b0, 2'd0, 4'd0} || obs_word(1) !== exp_word(1)) begin
      errs++;
      $display("FAIL clr_priority got=%h exp=%h", obs_word(1), exp_word(1));
    end
  endtask

  task automatic test_random;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < 2; i++)
        drive(i, ($urandom % 97) == 0, ($urandom % 10) != 0, ($urandom % 25) == 0,
              (($urandom % 4) == 0) ? 16'($urandom) : 16'h0);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_word(i) !== exp_word(i)) begin
          errs++;
          $display("FAIL random inst=%0d cyc=%0d got=%h exp=%h", i, cyc, obs_word(i), exp_word(i));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_run();
    test_single_branch();
    test_first_fail_order();
    test_rst_mid_check();
    test_fill_abort();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule
